// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state encoding and GF(2^8) helpers used by the
// iterative SubBytes block and its S-box wrappers.
package aes_pkg;

    localparam int AES_STATE_W   = 128;
    localparam int AES_BYTE_W    = 8;
    localparam int AES_NUM_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } sbi_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (t & {8{b[i]}});
            t = xtime(t);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x126, x127;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x126 = gf_mul(x120, x6);
        x127 = gf_mul(x126, x);
        return gf_mul(x127, x127);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
    endfunction

endpackage

// File: rtl/subbytes_iter_if.sv
// Input/output handshake bundle of the iterative SubBytes block.
interface subbytes_iter_if;
    import aes_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [AES_STATE_W-1:0] ip;
    logic                   enable;
    logic                   inv;
    logic                   out_valid;
    logic                   out_ready;
    logic [AES_STATE_W-1:0] op;

    modport master (
        output in_valid, ip, enable, inv, out_ready,
        input  in_ready, out_valid, op
    );

    modport slave (
        input  in_valid, ip, enable, inv, out_ready,
        output in_ready, out_valid, op
    );

endinterface

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [AES_BYTE_W-1:0] din,
    output logic [AES_BYTE_W-1:0] dout
);

    assign dout = sbox_fwd(din);

endmodule

// File: rtl/aes_sbox_fi.sv
// Forward/inverse S-box: wraps the forward aes_sbox and adds the inverse
// mapping only when INV_EN is set.
module aes_sbox_fi
    import aes_pkg::*;
#(
    parameter int INV_EN = 1
) (
    input  logic [AES_BYTE_W-1:0] din,
    input  logic                  inv,
    output logic [AES_BYTE_W-1:0] dout
);

    logic [AES_BYTE_W-1:0] fwd_s;

    aes_sbox u_fwd (
        .din  (din),
        .dout (fwd_s)
    );

    generate
        if (INV_EN != 0) begin : g_inv
            logic [AES_BYTE_W-1:0] inv_s;
            assign inv_s = sbox_inv(din);
            assign dout  = inv ? inv_s : fwd_s;
        end else begin : g_fwd_only
            logic unused_inv_s;
            assign unused_inv_s = inv;
            assign dout         = fwd_s;
        end
    endgenerate

endmodule

// File: rtl/subbytes_iter.sv
// Iterative AES (Inv)SubBytes: substitutes NUM_SBOX bytes of the captured
// state per cycle and presents the full result through a valid/ready handshake.
module subbytes_iter
    import aes_pkg::*;
#(
    parameter int NUM_SBOX = 4,
    parameter int INV_EN   = 1
) (
    input  logic           clk,
    input  logic           rst,
    subbytes_iter_if.slave bus
);

    localparam int               NUM_CHUNKS = AES_NUM_BYTES / NUM_SBOX;
    localparam int               CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(NUM_CHUNKS - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [3:0]       BYTE_STEP  = 4'(NUM_SBOX % AES_NUM_BYTES);

    generate
        if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4 ||
              NUM_SBOX == 8 || NUM_SBOX == 16)) begin : g_bad_num_sbox
            $error("subbytes_iter: NUM_SBOX must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    sbi_state_e            state_r;
    sbi_state_e            state_n_s;
    logic [CNT_W-1:0]      cnt_r;
    logic                  enable_r;
    logic                  inv_r;
    logic                  in_ready_r;
    logic                  out_valid_r;
    logic                  accept_s;
    logic                  sub_en_s;
    logic [AES_BYTE_W-1:0] cap_r       [AES_NUM_BYTES];
    logic [AES_BYTE_W-1:0] op_r        [AES_NUM_BYTES];
    logic [AES_BYTE_W-1:0] ip_bytes_s  [AES_NUM_BYTES];
    logic [AES_BYTE_W-1:0] sbox_din_s  [NUM_SBOX];
    logic [AES_BYTE_W-1:0] sbox_dout_s [NUM_SBOX];
    logic [3:0]            sbox_idx_s  [NUM_SBOX];
    logic [AES_STATE_W-1:0] op_flat_s;

    assign accept_s      = bus.in_valid && in_ready_r;
    assign sub_en_s      = (state_r == BUSY) && enable_r;
    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.op        = op_flat_s;

    // Next-state decode; out_ready only matters in DONE
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (bus.enable) begin
                        state_n_s = BUSY;
                    end else begin
                        state_n_s = DONE;
                    end
                end else begin
                    state_n_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == CNT_LAST) begin
                    state_n_s = DONE;
                end else begin
                    state_n_s = BUSY;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_n_s = IDLE;
                end else begin
                    state_n_s = DONE;
                end
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase
    end

    // Byte positions and S-box inputs of the chunk selected by the counter
    always_comb begin
        for (int j = 0; j < NUM_SBOX; j++) begin
            sbox_idx_s[j] = 4'(cnt_r) * BYTE_STEP + 4'(j);
            sbox_din_s[j] = cap_r[sbox_idx_s[j]];
        end
    end

    // Byte views of the input bus and flattened result register
    always_comb begin
        op_flat_s = {AES_STATE_W{1'b0}};
        for (int i = 0; i < AES_NUM_BYTES; i++) begin
            ip_bytes_s[i] = bus.ip[i*AES_BYTE_W +: AES_BYTE_W];
            op_flat_s[i*AES_BYTE_W +: AES_BYTE_W] = op_r[i];
        end
    end

    generate
        for (genvar g = 0; g < NUM_SBOX; g++) begin : g_sbox
            aes_sbox_fi #(
                .INV_EN (INV_EN)
            ) u_sbox (
                .din  (sbox_din_s[g]),
                .inv  (inv_r),
                .dout (sbox_dout_s[g])
            );
        end
    endgenerate

    // FSM state, handshake flags, captured input and result bytes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_ZERO;
            enable_r    <= 1'b0;
            inv_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            for (int i = 0; i < AES_NUM_BYTES; i++) begin
                cap_r[i] <= 8'h00;
                op_r[i]  <= 8'h00;
            end
        end else begin
            state_r     <= state_n_s;
            in_ready_r  <= (state_n_s == IDLE);
            out_valid_r <= (state_n_s == DONE);
            if (accept_s) begin
                // op starts as the input so untouched bytes read back unchanged
                enable_r <= bus.enable;
                inv_r    <= bus.inv & (INV_EN != 0);
                cnt_r    <= CNT_ZERO;
                for (int i = 0; i < AES_NUM_BYTES; i++) begin
                    cap_r[i] <= ip_bytes_s[i];
                    op_r[i]  <= ip_bytes_s[i];
                end
            end else if (sub_en_s) begin
                for (int j = 0; j < NUM_SBOX; j++) begin
                    op_r[sbox_idx_s[j]] <= sbox_dout_s[j];
                end
                cnt_r <= (cnt_r == CNT_LAST) ? CNT_ZERO : cnt_r + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_subbytes_iter.sv
// Directed, table-driven bench for subbytes_iter: main NUM_SBOX=4 instance plus
// a parameter sweep group (NUM_SBOX 1/2/8/16 and a forward-only instance).
module tb_subbytes_iter;
    import aes_pkg::*;

    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam int           SW_LAT [5] = '{17, 9, 3, 2, 5};

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    subbytes_iter_if dif();

    subbytes_iter #(
        .NUM_SBOX (4),
        .INV_EN   (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    logic         sw_in_valid;
    logic         sw_enable;
    logic         sw_inv;
    logic         sw_out_ready;
    logic [127:0] sw_ip;
    logic         sw_in_ready  [5];
    logic         sw_out_valid [5];
    logic [127:0] sw_op        [5];

    generate
        for (genvar k = 0; k < 5; k++) begin : g_sweep
            subbytes_iter_if bus();
            assign bus.in_valid    = sw_in_valid;
            assign bus.ip          = sw_ip;
            assign bus.enable      = sw_enable;
            assign bus.inv         = sw_inv;
            assign bus.out_ready   = sw_out_ready;
            assign sw_in_ready[k]  = bus.in_ready;
            assign sw_out_valid[k] = bus.out_valid;
            assign sw_op[k]        = bus.op;

            subbytes_iter #(
                .NUM_SBOX ((k < 2) ? (1 << k) : ((k < 4) ? (1 << (k + 1)) : 4)),
                .INV_EN   ((k < 4) ? 1 : 0)
            ) u_dut (
                .clk (clk),
                .rst (rst),
                .bus (bus)
            );
        end
    endgenerate

    typedef struct {
        logic [127:0] ip;
        logic         en;
        logic         inv;
        logic         early;
        logic [127:0] exp_op;
        int           exp_lat;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic run_txn(input string tag, input logic [127:0] ip, input logic en,
                           input logic inv, input logic early,
                           output logic [127:0] got_op, output int lat);
        @(negedge clk);
        check({tag, "_ready_before"}, 128'(dif.in_ready), 128'(1'b1));
        dif.ip        = ip;
        dif.enable    = en;
        dif.inv       = inv;
        dif.in_valid  = 1'b1;
        dif.out_ready = early;
        @(posedge clk);
        @(negedge clk);
        dif.in_valid = 1'b0;
        dif.ip       = ~ip;
        dif.enable   = ~en;
        dif.inv      = ~inv;
        lat = 1;
        while (dif.out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        got_op        = dif.op;
        dif.out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_release"}, 128'({dif.in_ready, dif.out_valid}), 128'(2'b10));
        dif.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] got;
        int           lat;
        int           w;
        logic [127:0] got_sw [5];
        int           lat_sw [5];
        bit           seen   [5];
        logic [127:0] exp_sw;

        rst           = 1'b1;
        dif.in_valid  = 1'b0;
        dif.ip        = 128'h0;
        dif.enable    = 1'b0;
        dif.inv       = 1'b0;
        dif.out_ready = 1'b0;
        sw_in_valid   = 1'b0;
        sw_ip         = 128'h0;
        sw_enable     = 1'b0;
        sw_inv        = 1'b0;
        sw_out_ready  = 1'b0;

        vecs[0] = '{FIPS_IN,  1'b1, 1'b0, 1'b0, FIPS_OUT, 5};
        vecs[1] = '{FIPS_OUT, 1'b1, 1'b1, 1'b0, FIPS_IN,  5};
        vecs[2] = '{{16{8'h00}}, 1'b1, 1'b0, 1'b0, {16{8'h63}}, 5};
        vecs[3] = '{{16{8'h63}}, 1'b1, 1'b1, 1'b0, {16{8'h00}}, 5};
        vecs[4] = '{{16{8'h53}}, 1'b1, 1'b0, 1'b1, {16{8'hed}}, 5};
        vecs[5] = '{{16{8'hed}}, 1'b1, 1'b1, 1'b0, {16{8'h53}}, 5};
        vecs[6] = '{128'h00112233445566778899aabbccddeeff, 1'b0, 1'b0, 1'b0,
                    128'h00112233445566778899aabbccddeeff, 1};
        vecs[7] = '{FIPS_IN, 1'b0, 1'b1, 1'b1, FIPS_IN, 1};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_op", dif.op, 128'h0);
        check("rst_out_valid", 128'(dif.out_valid), 128'(1'b0));
        check("rst_in_ready", 128'(dif.in_ready), 128'(1'b1));
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rst_sweep%0d_op", k), sw_op[k], 128'h0);
        end

        // reset wins over a simultaneous accept and out_ready
        dif.ip        = FIPS_IN;
        dif.enable    = 1'b1;
        dif.in_valid  = 1'b1;
        dif.out_ready = 1'b1;
        @(negedge clk);
        check("rst_prio_state", 128'({dif.in_ready, dif.out_valid}), 128'(2'b10));
        check("rst_prio_op", dif.op, 128'h0);
        dif.in_valid  = 1'b0;
        dif.out_ready = 1'b0;
        rst           = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 128'(dif.in_ready), 128'(1'b1));
        check("post_rst_op", dif.op, 128'h0);

        // table of directed vectors
        for (int i = 0; i < 8; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].ip, vecs[i].en, vecs[i].inv,
                    vecs[i].early, got, lat);
            check($sformatf("vec%0d_op", i), got, vecs[i].exp_op);
            check($sformatf("vec%0d_lat", i), 128'(lat), 128'(vecs[i].exp_lat));
        end

        // hold in DONE with out_ready low; input activity must be ignored
        @(negedge clk);
        dif.ip       = FIPS_IN;
        dif.enable   = 1'b1;
        dif.inv      = 1'b0;
        dif.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dif.in_valid = 1'b0;
        w = 1;
        while (dif.out_valid !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("hold_lat", 128'(w), 128'(5));
        for (int c = 0; c < 10; c++) begin
            check("hold_op", dif.op, FIPS_OUT);
            check("hold_out_valid", 128'(dif.out_valid), 128'(1'b1));
            check("hold_in_ready", 128'(dif.in_ready), 128'(1'b0));
            dif.in_valid = c[0];
            dif.ip       = {$urandom, $urandom, $urandom, $urandom};
            dif.inv      = c[1];
            @(negedge clk);
        end
        dif.in_valid  = 1'b1;
        dif.out_ready = 1'b1;
        @(negedge clk);
        check("hold_exit_state", 128'({dif.in_ready, dif.out_valid}), 128'(2'b10));
        check("hold_exit_op", dif.op, FIPS_OUT);
        dif.in_valid  = 1'b0;
        dif.out_ready = 1'b0;

        // reset in the second BUSY cycle discards the partial result
        @(negedge clk);
        dif.ip       = FIPS_IN;
        dif.enable   = 1'b1;
        dif.inv      = 1'b0;
        dif.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dif.in_valid = 1'b0;
        check("busy1_op", dif.op, FIPS_IN);
        check("busy1_state", 128'({dif.in_ready, dif.out_valid}), 128'(2'b00));
        @(negedge clk);
        check("busy2_op", dif.op, 128'h193de3bea0f4e22b9ac68d2a_1e415230);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_op", dif.op, 128'h0);
        check("midrst_state", 128'({dif.in_ready, dif.out_valid}), 128'(2'b10));
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 128'(dif.in_ready), 128'(1'b1));
        run_txn("after_rst", FIPS_IN, 1'b1, 1'b0, 1'b0, got, lat);
        check("after_rst_op", got, FIPS_OUT);
        check("after_rst_lat", 128'(lat), 128'(5));

        // NUM_SBOX sweep, forward then inverse
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            for (int k = 0; k < 5; k++) begin
                check($sformatf("sw%0d_r%0d_ready", k, r), 128'(sw_in_ready[k]), 128'(1'b1));
                seen[k]   = 1'b0;
                lat_sw[k] = 0;
                got_sw[k] = 128'h0;
            end
            sw_ip       = (r == 0) ? FIPS_IN : {16{8'h53}};
            sw_inv      = (r == 1);
            sw_enable   = 1'b1;
            sw_in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            sw_in_valid = 1'b0;
            sw_ip       = 128'h0;
            for (int cyc = 1; cyc <= 20; cyc++) begin
                for (int k = 0; k < 5; k++) begin
                    if (!seen[k] && sw_out_valid[k] === 1'b1) begin
                        seen[k]   = 1'b1;
                        lat_sw[k] = cyc;
                        got_sw[k] = sw_op[k];
                    end
                end
                @(negedge clk);
            end
            for (int k = 0; k < 5; k++) begin
                if (r == 0) exp_sw = FIPS_OUT;
                else if (k < 4) exp_sw = {16{8'h50}};
                else exp_sw = {16{8'hed}};
                check($sformatf("sw%0d_r%0d_op", k, r), got_sw[k], exp_sw);
                check($sformatf("sw%0d_r%0d_lat", k, r), 128'(lat_sw[k]), 128'(SW_LAT[k]));
            end
            sw_out_ready = 1'b1;
            @(negedge clk);
            sw_out_ready = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
